// File: rtl/lut_divider_4b_seq.sv
`default_nettype none
// ============================================================================
//  Module      : lut_divider_4b_seq
//  Description : Sequential radix-16 divider. Divides an unsigned DIVIDEND_W
//                dividend by a 4-bit unsigned divisor. A registered table of
//                divisor multiples (d*0..d*15) is built once per operation,
//                then one quotient nibble is retired per clock, MSB first,
//                by comparing the partial value against the table.
//  Revision    : 1.0 - initial release
// ============================================================================
module lut_divider_4b_seq #(
    parameter int DIVIDEND_W = 32,
    parameter int DIGITS     = DIVIDEND_W / 4
) (
    input  logic                  clk_4b,
    input  logic                  resetn_4b,
    input  logic                  start_4b,
    input  logic [DIVIDEND_W-1:0] dividend_4b,
    input  logic [3:0]            divisor_4b,
    output logic                  busy_4b,
    output logic                  done_4b,
    output logic [DIVIDEND_W-1:0] quotient_4b,
    output logic [3:0]            remainder_4b,
    output logic                  div_zero_4b
);

    localparam int c_cnt_w = $clog2(DIGITS + 1);
    localparam logic [c_cnt_w-1:0] c_last_digit = c_cnt_w'(DIGITS - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_load = 2'd1;
    localparam logic [1:0] c_st_iter = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    logic [1:0]            r_state;
    logic [DIVIDEND_W-1:0] r_dvd;        // dividend, shifted left one nibble per digit
    logic [3:0]            r_divisor;
    logic [3:0]            r_rem;        // partial remainder
    logic [DIVIDEND_W-1:0] r_qsr;        // quotient shift register
    logic [c_cnt_w-1:0]    r_cnt;
    logic [7:0]            r_mult [16];  // d*k multiples table
    logic                  r_busy;
    logic                  r_done;
    logic [DIVIDEND_W-1:0] r_quotient;
    logic [3:0]            r_remainder;
    logic                  r_div_zero;

    logic [7:0]            w_d_ext;
    logic [7:0]            w_mult_next [16];
    logic [7:0]            w_v;
    logic [3:0]            w_q;
    logic [3:0]            w_rem_next;
    logic [DIVIDEND_W-1:0] w_qsr_next;

    assign w_d_ext = {4'b0000, r_divisor};

    // Each table entry is the shift-add sum of the divisor weighted by the bits of k.
    genvar gk;
    generate
        for (gk = 0; gk < 16; gk++) begin : g_mult
            localparam logic [3:0] c_k = 4'(gk);
            assign w_mult_next[gk] = (c_k[0] ? w_d_ext        : 8'd0)
                                   + (c_k[1] ? (w_d_ext << 1) : 8'd0)
                                   + (c_k[2] ? (w_d_ext << 2) : 8'd0)
                                   + (c_k[3] ? (w_d_ext << 3) : 8'd0);
        end
    endgenerate

    // Current partial value: previous remainder with the next dividend nibble appended.
    assign w_v = {r_rem, r_dvd[DIVIDEND_W-1 -: 4]};

    // Digit select: the table is monotonic for d != 0, so the last k with mult[k] <= v wins.
    always_comb begin
        w_q = 4'd0;
        for (int k = 1; k < 16; k++) begin
            if (r_mult[k] <= w_v) begin
                w_q = 4'(k);
            end
        end
    end

    // True difference is below 16, so the low nibbles alone give it exactly.
    assign w_rem_next = w_v[3:0] - r_mult[w_q][3:0];
    assign w_qsr_next = {r_qsr[DIVIDEND_W-5:0], w_q};

    // Control FSM, table, datapath and registered result outputs.
    always_ff @(posedge clk_4b or negedge resetn_4b) begin
        if (!resetn_4b) begin
            r_state     <= c_st_idle;
            r_dvd       <= '0;
            r_divisor   <= '0;
            r_rem       <= '0;
            r_qsr       <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
            for (int k = 0; k < 16; k++) begin
                r_mult[k] <= '0;
            end
        end else begin
            case (r_state)
                c_st_idle, c_st_done: begin
                    r_done <= 1'b0;
                    if (start_4b) begin
                        r_dvd     <= dividend_4b;
                        r_divisor <= divisor_4b;
                        r_rem     <= '0;
                        r_qsr     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= c_st_load;
                    end else begin
                        r_state   <= c_st_idle;
                    end
                end
                c_st_load: begin
                    if (r_divisor != 4'd0) begin
                        for (int k = 0; k < 16; k++) begin
                            r_mult[k] <= w_mult_next[k];
                        end
                        r_cnt   <= '0;
                        r_state <= c_st_iter;
                    end else begin
                        // Division by zero: saturated quotient, low nibble as remainder.
                        r_quotient  <= '1;
                        r_remainder <= r_dvd[3:0];
                        r_div_zero  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= c_st_done;
                    end
                end
                c_st_iter: begin
                    r_rem <= w_rem_next;
                    r_qsr <= w_qsr_next;
                    r_dvd <= {r_dvd[DIVIDEND_W-5:0], 4'b0000};
                    r_cnt <= r_cnt + c_cnt_one;
                    if (r_cnt == c_last_digit) begin
                        r_quotient  <= w_qsr_next;
                        r_remainder <= w_rem_next;
                        r_div_zero  <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= c_st_done;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign busy_4b      = r_busy;
    assign done_4b      = r_done;
    assign quotient_4b  = r_quotient;
    assign remainder_4b = r_remainder;
    assign div_zero_4b  = r_div_zero;

endmodule
`default_nettype wire

// File: tb/tb_lut_divider_4b_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lut_divider_4b_seq
//  Description : Self-checking bench for lut_divider_4b_seq. An arithmetic
//                reference model predicts handshake and results every cycle;
//                directed operations are also checked against literals.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lut_divider_4b_seq;

    localparam int DIVIDEND_W = 32;

    logic                  clk;
    logic                  resetn;
    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [3:0]            divisor;
    logic                  busy;
    logic                  done;
    logic [DIVIDEND_W-1:0] quotient;
    logic [3:0]            remainder;
    logic                  div_zero;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0     = 0;

    lut_divider_4b_seq #(.DIVIDEND_W(DIVIDEND_W)) dut (
        .clk_4b       (clk),
        .resetn_4b    (resetn),
        .start_4b     (start),
        .dividend_4b  (dividend),
        .divisor_4b   (divisor),
        .busy_4b      (busy),
        .done_4b      (done),
        .quotient_4b  (quotient),
        .remainder_4b (remainder),
        .div_zero_4b  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: an operation takes 9 edges (1 for a zero divisor)
    // from its accepting edge to the done pulse; results are plain / and %.
    logic                  m_busy, m_done, m_dz;
    logic [DIVIDEND_W-1:0] m_q, m_a;
    logic [3:0]            m_r, m_d;
    int                    m_left;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
            m_q = '0; m_r = '0; m_a = '0; m_d = '0; m_left = 0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                if (m_d == 4'd0) begin
                    m_q  = '1;
                    m_r  = m_a[3:0];
                    m_dz = 1'b1;
                end else begin
                    m_q  = m_a / DIVIDEND_W'(m_d);
                    m_r  = 4'(m_a % DIVIDEND_W'(m_d));
                    m_dz = 1'b0;
                end
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_a    = dividend;
                m_d    = divisor;
                m_busy = 1'b1;
                m_left = (divisor == 4'd0) ? 1 : 9;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("busy",      busy,      m_busy);
        check("done",      done,      m_done);
        check("quotient",  quotient,  m_q);
        check("remainder", remainder, m_r);
        check("div_zero",  div_zero,  m_dz);
    end

    // Present an operation for exactly one edge; returns at posedge+1.
    task automatic start_op(input logic [DIVIDEND_W-1:0] a, input logic [3:0] d);
        start    = 1'b1;
        dividend = a;
        divisor  = d;
        @(posedge clk); #1;
        t0    = cyc;
        start = 1'b0;
    endtask

    // Wait (bounded) for done and check latency against the accepting edge.
    task automatic wait_done(input string name, input int exp_lat);
        int n = 0;
        while (!done && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_latency"}, 64'(cyc - t0), 64'(exp_lat));
    endtask

    task automatic check_res(input string name, input logic [DIVIDEND_W-1:0] q,
                             input logic [3:0] r, input logic dz);
        check({name, "_q"},  quotient,  q);
        check({name, "_r"},  remainder, r);
        check({name, "_dz"}, div_zero,  dz);
    endtask

    initial begin
        logic [DIVIDEND_W-1:0] a;
        logic [3:0]            d;
        logic                  saw_done;

        resetn = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        #22;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check_res("reset", 32'h0, 4'h0, 1'b0);
        resetn = 1'b1;
        @(posedge clk); #1;

        start_op(32'd100, 4'd7);
        wait_done("op100_7", 9);
        check_res("op100_7", 32'd14, 4'd2, 1'b0);
        @(posedge clk); #1;

        start_op(32'hFFFF_FFFF, 4'd15);
        wait_done("opF_15", 9);
        check_res("opF_15", 32'h1111_1111, 4'd0, 1'b0);
        @(posedge clk); #1;

        start_op(32'hFFFF_FFFF, 4'd1);
        wait_done("opF_1", 9);
        check_res("opF_1", 32'hFFFF_FFFF, 4'd0, 1'b0);
        @(posedge clk); #1;

        start_op(32'h1234_5678, 4'd0);
        wait_done("divzero", 1);
        check_res("divzero", 32'hFFFF_FFFF, 4'd8, 1'b1);
        @(posedge clk); #1;

        start_op(32'h1234_5678, 4'd9);
        wait_done("op1234_9", 9);
        check_res("op1234_9", 32'h0205_D0B8, 4'd0, 1'b0);
        @(posedge clk); #1;

        // A start while busy must be ignored.
        start_op(32'd50, 4'd3);
        repeat (3) begin @(posedge clk); #1; end
        start = 1'b1; dividend = 32'd99; divisor = 4'd9;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("op50_3", 9);
        check_res("op50_3", 32'd16, 4'd2, 1'b0);

        // Start in the DONE cycle is accepted back-to-back.
        start_op(32'd99, 4'd9);
        wait_done("op99_9", 9);
        check_res("op99_9", 32'd11, 4'd0, 1'b0);
        @(posedge clk); #1;

        // Asynchronous reset mid-operation.
        start_op(32'd1000, 4'd13);
        repeat (4) begin @(posedge clk); #1; end
        resetn = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check_res("midrst", 32'h0, 4'h0, 1'b0);
        @(posedge clk); #1;
        resetn = 1'b1;
        saw_done = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        check("midrst_no_done", saw_done, 1'b0);

        start_op(32'd1000, 4'd13);
        wait_done("op1000_13", 9);
        check_res("op1000_13", 32'd76, 4'd12, 1'b0);

        // Random sweep with the division identity.
        for (int i = 0; i < 1500; i++) begin
            a = $urandom;
            d = 4'($urandom_range(0, 15));
            start_op(a, d);
            wait_done("rand", (d == 4'd0) ? 1 : 9);
            if (d != 4'd0) begin
                check("rand_identity",
                      64'(quotient) * 64'(d) + 64'(remainder), 64'(a));
                check("rand_rem_lt_d", 64'(remainder < d), 64'd1);
            end else begin
                check_res("rand_zero", 32'hFFFF_FFFF, a[3:0], 1'b1);
            end
        end

        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
